// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// The stage map names the default 4-stage layout, with index 0 as the youngest stage.
package pipe_hazard_ctrl_pkg;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int DEF_STAGES = 4;
  typedef logic [$clog2(DEF_STAGES)-1:0] stage_idx_t;

  localparam stage_idx_t STG_PC     = stage_idx_t'(0);
  localparam stage_idx_t STG_IF_ID  = stage_idx_t'(1);
  localparam stage_idx_t STG_ID_EX  = stage_idx_t'(2);
  localparam stage_idx_t STG_EX_MEM = stage_idx_t'(3);
endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
// Clear takes priority over enable.
module sat_counter
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall, bubble and flush control for an N-stage in-order pipeline.
// Adds a pending-flush latch, a post-flush fetch hold, a stall counter and a deadlock watchdog.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int FLUSH_HOLD = 1,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] flush_req,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] bubble_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  flush_pend_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic                  deadlock_o
);

  localparam int IDX_W  = $clog2(NUM_STAGES);
  localparam int HOLD_W = (FLUSH_HOLD > 0) ? $clog2(FLUSH_HOLD + 1) : 1;
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  typedef logic [IDX_W-1:0] idx_t;

  logic [NUM_STAGES-1:0] s;
  logic [NUM_STAGES-1:0] held;
  logic                  k_vld, pend_use, fl_vld, lat_vld, keep_vld;
  idx_t                  k_idx, fl_idx, lat_idx;
  logic                  pend_vld_nxt;
  idx_t                  pend_idx_nxt;

  logic                  pend_vld_p0;
  idx_t                  pend_idx_p0;
  logic [HOLD_W-1:0]     hold_cnt_p0;
  logic                  deadlock_p0;
  logic [WD_W-1:0]       wd_cnt;
  logic                  stall_adv;

  always_comb begin
    logic acc;
    acc = FALSE;
    s   = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      acc  = acc | stall_req[i];
      s[i] = acc;
    end
  end

  // A stage is held when anything older than it stalls.
  assign held = {1'b0, s[NUM_STAGES-1:1]};

  always_comb begin
    k_vld = FALSE;
    k_idx = '0;
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (flush_req[i] && !held[i]) begin
        k_vld = TRUE;
        k_idx = idx_t'(i);
      end
    end
  end

  always_comb begin
    pend_use = pend_vld_p0 && !held[pend_idx_p0];
    fl_vld   = k_vld || pend_use;
    fl_idx   = k_idx;
    if (pend_use && (!k_vld || pend_idx_p0 > k_idx)) fl_idx = pend_idx_p0;
  end

  // Held requests below an applied flush are killed with their stage, so they are not latched.
  always_comb begin
    lat_vld = FALSE;
    lat_idx = '0;
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (flush_req[i] && held[i] && (!fl_vld || idx_t'(i) > fl_idx)) begin
        lat_vld = TRUE;
        lat_idx = idx_t'(i);
      end
    end
  end

  always_comb begin
    keep_vld     = pend_vld_p0 && !(fl_vld && pend_idx_p0 <= fl_idx);
    pend_vld_nxt = keep_vld || lat_vld;
    pend_idx_nxt = keep_vld ? pend_idx_p0 : '0;
    if (lat_vld && (!keep_vld || lat_idx > pend_idx_p0)) pend_idx_nxt = lat_idx;
  end

  always_comb begin
    stall_o  = '0;
    flush_o  = '0;
    bubble_o = '0;
    if (!rst_n) begin
      stall_o = '0;
    end else if (!rdy) begin
      stall_o = '1;
    end else begin
      stall_o = s;
      for (int j = 0; j < NUM_STAGES; j++) begin
        if (fl_vld && idx_t'(j) < fl_idx) begin
          flush_o[j] = TRUE;
          stall_o[j] = FALSE;
        end
      end
      if (!fl_vld && hold_cnt_p0 != '0) flush_o[STG_PC] = TRUE;
      for (int i = 1; i < NUM_STAGES; i++) begin
        bubble_o[i] = stall_o[i-1] & ~stall_o[i] & ~flush_o[i];
      end
    end
  end

  assign stall_adv = rdy && stall_o[0];

  // ---- stage p0: controller state, frozen while rdy is low ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_p0 <= FALSE;
      pend_idx_p0 <= '0;
      hold_cnt_p0 <= '0;
      deadlock_p0 <= FALSE;
    end else if (rdy) begin
      pend_vld_p0 <= pend_vld_nxt;
      pend_idx_p0 <= pend_idx_nxt;
      if (fl_vld)                  hold_cnt_p0 <= HOLD_W'(FLUSH_HOLD);
      else if (hold_cnt_p0 != '0)  hold_cnt_p0 <= hold_cnt_p0 - 1'b1;
      if (stall_adv && wd_cnt >= WD_W'(TIMEOUT - 1)) deadlock_p0 <= TRUE;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_adv),
    .clr   (FALSE),
    .cnt   (stall_cnt_o)
  );

  sat_counter #(.CNT_W(WD_W)) u_wd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_adv),
    .clr   (rdy && !stall_o[0]),
    .cnt   (wd_cnt)
  );

  assign flush_pend_o = pend_vld_p0;
  assign deadlock_o   = deadlock_p0;

endmodule
